exp_align_pipe: RTL and testbench

Pipelined, parametrised exponent-alignment unit for the multi-input PE datapath. It accepts one vector of `LANES` biased exponents per transaction, with a per-lane valid mask, and finds the maximum exponent over the unmasked lanes. For each lane it produces the right-shift distance needed to align that lane's mantissa to the maximum, saturated to the mantissa-aligner range. It generalises the fixed 16-input combinational max/shift tree: lane count and grouping are parametrised, a two-stage registered pipeline is added, and valid/ready flow control, lane masking and shift saturation are new.

---
 rtl/exp_align_pkg.sv | 25 ++
 rtl/exp_align_pipe_group_max.sv | 25 ++
 rtl/exp_align_pipe.sv | 126 ++++++++++++
 tb/tb_exp_align_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_align_pkg.sv
// Shared types and helpers for the exponent-alignment pipeline.
package exp_align_pkg;

  localparam int EXP_W  = 11;  // default exponent width
  localparam int CALC_W = 32;  // working width of the shift helper; covers any legal WIDTH

  typedef logic [EXP_W-1:0] exp_t;

  // Number of first-level max groups.
  function automatic int grp_cnt(input int lanes, input int group);
    return lanes / group;
  endfunction

  // Alignment distance clamped to sat_v; result is {sat_flag, shift}.
  // The caller guarantees max_e >= exp_e, so the difference is never negative.
  function automatic logic [CALC_W:0] sat_shift(input logic [CALC_W-1:0] max_e,
                                                input logic [CALC_W-1:0] exp_e,
                                                input logic [CALC_W-1:0] sat_v);
    logic [CALC_W-1:0] d;
    d = max_e - exp_e;
    if (d > sat_v) return {1'b1, sat_v};
    else           return {1'b0, d};
  endfunction

endpackage

// File: rtl/exp_align_pipe_group_max.sv
// Combinational masked maximum over N exponents; masked entries contribute 0.
module exp_group_max #(
  parameter int WIDTH = 11,
  parameter int N     = 4
) (
  input  logic [N*WIDTH-1:0] exp_vec,
  input  logic [N-1:0]       mask,
  output logic [WIDTH-1:0]   max_exp,
  output logic               any_valid
);

  // Linear scan; ties need no priority since only the value is reported.
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    max_exp   = '0;
    any_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        any_valid = 1'b1;
        if (exp_vec[i*WIDTH +: WIDTH] > max_exp) max_exp = exp_vec[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/exp_align_pipe.sv
// Two-stage exponent-alignment pipeline: stage 1 registers inputs and group
// maxima, stage 2 reduces to the global max and registers per-lane shifts.
module exp_align_pipe
  import exp_align_pkg::*;
#(
  parameter int WIDTH     = EXP_W,
  parameter int LANES     = 16,
  parameter int GROUP     = 4,
  parameter int SHIFT_SAT = 31
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_exp,
  input  logic [LANES-1:0]       in_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_exp_max,
  output logic [LANES*WIDTH-1:0] out_shift,
  output logic [LANES-1:0]       out_sat,
  output logic                   out_all_masked
);

  localparam int NG = grp_cnt(LANES, GROUP);

  // Handshake and per-stage valid bits.
  logic v1, v2;
  logic load1, load2, in_xfer;

  assign load2     = !v2 || out_ready;
  assign load1     = !v1 || load2;
  assign in_ready  = load1;  // equals !v1 || !v2 || out_ready
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = v2;

  // Stage 1: group maxima computed from the live input.
  logic [NG*WIDTH-1:0] gmax_d;
  logic [NG-1:0]       gany_d;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    exp_group_max #(.WIDTH(WIDTH), .N(GROUP)) u_grp (
      .exp_vec  (in_exp[g*GROUP*WIDTH +: GROUP*WIDTH]),
      .mask     (in_mask[g*GROUP +: GROUP]),
      .max_exp  (gmax_d[g*WIDTH +: WIDTH]),
      .any_valid(gany_d[g])
    );
  end

  logic [LANES*WIDTH-1:0] s1_exp;
  logic [LANES-1:0]       s1_mask;
  logic [NG*WIDTH-1:0]    s1_gmax;
  logic [NG-1:0]          s1_gany;

  // Stage 1 registers: valid advances on every load, payload only on a real transfer.
  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      // NOTE: payload is reset too; it is a handful of flops, not a memory array, so the cost is trivial.
      s1_exp  <= '0;
      s1_mask <= '0;
      s1_gmax <= '0;
      s1_gany <= '0;
    end else if (load1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_exp  <= in_exp;
        s1_mask <= in_mask;
        s1_gmax <= gmax_d;
        s1_gany <= gany_d;
      end
    end
  end

  // Stage 2: global max over group maxima; an empty group reports 0 and is masked out.
  logic [WIDTH-1:0] max_d;
  logic             any_d;

  exp_group_max #(.WIDTH(WIDTH), .N(NG)) u_top (
    .exp_vec  (s1_gmax),
    .mask     (s1_gany),
    .max_exp  (max_d),
    .any_valid(any_d)
  );

  logic [LANES*WIDTH-1:0] shift_d;
  logic [LANES-1:0]       sat_d;

  // Per-lane shift with saturation; masked lanes flush with a full shift and no sat flag.
  always_comb begin
    logic [CALC_W:0] r;
    r       = '0;
    shift_d = '0;
    sat_d   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s1_mask[i]) begin
        r = sat_shift(CALC_W'(max_d), CALC_W'(s1_exp[i*WIDTH +: WIDTH]), CALC_W'(SHIFT_SAT));
        shift_d[i*WIDTH +: WIDTH] = r[WIDTH-1:0];
        sat_d[i]                  = r[CALC_W];
      end else begin
        shift_d[i*WIDTH +: WIDTH] = WIDTH'(SHIFT_SAT);
      end
    end
  end

  // Stage 2 registers: hold while stalled, payload only when stage 1 holds data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2             <= 1'b0;
      out_exp_max    <= '0;
      out_shift      <= '0;
      out_sat        <= '0;
      out_all_masked <= 1'b0;
    end else if (load2) begin
      v2 <= v1;
      if (v1) begin
        out_exp_max    <= max_d;
        out_shift      <= shift_d;
        out_sat        <= sat_d;
        out_all_masked <= !any_d;
      end
    end
  end

endmodule

// File: tb/tb_exp_align_pipe.sv
// Randomised scoreboard bench for exp_align_pipe with directed corner vectors.
module tb_exp_align_pipe;

  localparam int W   = 11;
  localparam int L   = 16;
  localparam int G   = 4;
  localparam int SAT = 31;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [L*W-1:0] in_exp;
  logic [L-1:0]   in_mask;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_exp_max;
  logic [L*W-1:0] out_shift;
  logic [L-1:0]   out_sat;
  logic           out_all_masked;

  exp_align_pipe #(.WIDTH(W), .LANES(L), .GROUP(G), .SHIFT_SAT(SAT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_exp        (in_exp),
    .in_mask       (in_mask),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_exp_max   (out_exp_max),
    .out_shift     (out_shift),
    .out_sat       (out_sat),
    .out_all_masked(out_all_masked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]   mx;
    logic [L*W-1:0] sh;
    logic [L-1:0]   sat;
    logic           all_m;
  } res_t;

  res_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: integer max over participating lanes, then clamped differences.
  function automatic res_t model(input logic [L*W-1:0] e, input logic [L-1:0] m);
    res_t r;
    int   mx, any, d, ev;
    mx = 0; any = 0;
    for (int i = 0; i < L; i++) begin
      ev = int'(e[i*W +: W]);
      if (m[i]) begin
        any = 1;
        if (ev > mx) mx = ev;
      end
    end
    r.mx = W'(mx); r.all_m = (any == 0); r.sh = '0; r.sat = '0;
    for (int i = 0; i < L; i++) begin
      if (!m[i]) r.sh[i*W +: W] = W'(SAT);
      else begin
        d = mx - int'(e[i*W +: W]);
        if (d > SAT) begin r.sh[i*W +: W] = W'(SAT); r.sat[i] = 1'b1; end
        else         r.sh[i*W +: W] = W'(d);
      end
    end
    return r;
  endfunction

  // Monitor: samples on the falling edge, compares output transfers, checks stall stability,
  // and records input transfers into the scoreboard.
  res_t prev;
  bit   prev_stall = 0;
  always @(negedge clk) begin
    res_t e;
    if (!rst_n || !mon_en) prev_stall = 0;
    else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {out_exp_max, out_shift, out_sat, out_all_masked}, prev);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("unexpected_output", out_valid, 0);
        else begin
          e = sb_q.pop_front();
          check("exp_max", out_exp_max, e.mx);
          check("shift", out_shift, e.sh);
          check("sat", out_sat, e.sat);
          check("all_masked", out_all_masked, e.all_m);
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(in_exp, in_mask));
      prev_stall = out_valid && !out_ready;
      prev       = {out_exp_max, out_shift, out_sat, out_all_masked};
    end
  end

  // Present a vector until accepted; call and return just after a rising edge.
  task automatic send(input logic [L*W-1:0] e, input logic [L-1:0] m);
    bit acc;
    in_valid = 1'b1; in_exp = e; in_mask = m; acc = 0;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout: input never accepted");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(negedge clk);
    check(name, sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_max"}, out_exp_max, 0);
    check({tag, "_shift"}, out_shift, 0);
    check({tag, "_sat"}, out_sat, 0);
    check({tag, "_all_masked"}, out_all_masked, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  logic [L*W-1:0] v, exp_sh;
  bit             rnd_done;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_exp = '0; in_mask = '0; out_ready = 1'b0;
    #12;
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1; mon_en = 1; out_ready = 1'b1;

    // Ramp: known answer plus latency (stage 1 at the accept edge, stage 2 on the next).
    for (int i = 0; i < L; i++) v[i*W +: W] = W'(100 + i);
    send(v, '1);
    @(negedge clk); check("ramp_lat_stage1", out_valid, 0);
    @(negedge clk); check("ramp_lat_stage2", out_valid, 1);
    for (int i = 0; i < L; i++) exp_sh[i*W +: W] = W'(15 - i);
    check("ramp_max", out_exp_max, 115);
    check("ramp_shift", out_shift, exp_sh);
    check("ramp_sat", out_sat, 0);
    @(posedge clk); #1;

    // Saturation.
    for (int i = 0; i < L; i++) v[i*W +: W] = W'(1);
    v[0 +: W] = W'(2047); v[W +: W] = W'(2000);
    send(v, '1);
    // Masked maximum.
    for (int i = 0; i < L; i++) v[i*W +: W] = W'(50 + i);
    v[7*W +: W] = W'(2047);
    send(v, ~(L'(1) << 7));
    // All masked and a single-lane vector.
    send(v, '0);
    send(v, L'(1) << 3);
    wait_drain("directed_drain");

    // Backpressure: A and B fill the pipe, C waits, A held stable.
    out_ready = 1'b0;
    for (int i = 0; i < L; i++) v[i*W +: W] = W'(500);
    send(v, '1);
    for (int i = 0; i < L; i++) v[i*W +: W] = W'(600 - 3 * i);
    send(v, '1);
    for (int i = 0; i < L; i++) v[i*W +: W] = W'(700 + 7 * i);
    in_valid = 1'b1; in_exp = v; in_mask = 16'h0ff0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 0);
      check("bp_a_held", out_exp_max, 500);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk); check("bp_in_ready_high", in_ready, 1);
    @(posedge clk); #1; in_valid = 1'b0;
    wait_drain("bp_drain");

    // Random traffic with random downstream stalls.
    rnd_done = 0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          logic [L*W-1:0] rv;
          logic [L-1:0]   rm;
          int base;
          base = $urandom_range(0, 2047);
          for (int i = 0; i < L; i++) begin
            int x;
            x = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2047)
                                            : base - $urandom_range(0, 40);
            if (x < 0) x = 0;
            rv[i*W +: W] = W'(x);
          end
          case ($urandom_range(0, 9))
            0:       rm = '0;
            1, 2, 3: rm = L'($urandom);
            default: rm = '1;
          endcase
          send(rv, rm);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain("random_drain");

    // Reset with two vectors in flight.
    out_ready = 1'b0;
    for (int i = 0; i < L; i++) v[i*W +: W] = W'(900 + i);
    send(v, '1);
    send(v, '1);
    #2;
    rst_n = 1'b0; mon_en = 0;
    #1;
    check_outputs_zero("midreset");
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; mon_en = 1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check("post_reset_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < L; i++) v[i*W +: W] = W'(40 + 2 * i);
    send(v, '1);
    @(negedge clk); check("post_reset_lat_stage1", out_valid, 0);
    @(negedge clk); check("post_reset_lat_stage2", out_valid, 1);
    check("post_reset_max", out_exp_max, 70);
    @(posedge clk); #1;
    wait_drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
